// File: rtl/password_confirm.sv
// 4-digit BCD password checker: stores a code, rewrites it on changePass, compares on confirmPass.
// Optional lockout after repeated failed attempts is built when CONFIRM_LOCKOUT_EN is defined.
module password_confirm #(
  parameter logic [15:0] DEFAULT_PASS = 16'h4781
`ifdef CONFIRM_LOCKOUT_EN
  ,
  parameter int unsigned MAX_TRIES    = 3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        changePass,
  input  logic        confirmPass,
  input  logic [15:0] password,
  output logic        error,
  output logic        right
);

  typedef enum logic [1:0] {StIdle, StChange, StCheck, StLocked} state_e;

  state_e      state_q;
  logic [15:0] memory_q;
  logic        pass_bcd;
  logic        match;

`ifdef CONFIRM_LOCKOUT_EN
  logic [1:0]  fail_q;
  logic        confirm_q;
`endif

  always_comb begin
    pass_bcd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (password[4*i +: 4] > 4'd9) pass_bcd = 1'b0;
    end
  end

  assign match = (password == memory_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      memory_q <= DEFAULT_PASS;
      right    <= 1'b0;
      error    <= 1'b0;
`ifdef CONFIRM_LOCKOUT_EN
      fail_q    <= 2'd0;
      confirm_q <= 1'b0;
`endif
    end else begin
`ifdef CONFIRM_LOCKOUT_EN
      confirm_q <= confirmPass;
`endif
      case (state_q)
        StIdle, StChange, StCheck: begin
          if (changePass) begin
            // Write wins over compare; a non-BCD code is dropped and flagged.
            state_q <= StChange;
            right   <= 1'b0;
            error   <= ~pass_bcd;
            if (pass_bcd) begin
              memory_q <= password;
`ifdef CONFIRM_LOCKOUT_EN
              fail_q   <= 2'd0;
`endif
            end
          end else if (confirmPass) begin
            state_q <= StCheck;
            right   <= match;
            error   <= ~match;
`ifdef CONFIRM_LOCKOUT_EN
            // Only the first cycle of a confirm pulse counts as an attempt.
            if (!confirm_q) begin
              if (match) begin
                fail_q <= 2'd0;
              end else begin
                if (fail_q != 2'd3) fail_q <= fail_q + 2'd1;
                if (32'(fail_q) + 32'd1 >= MAX_TRIES) state_q <= StLocked;
              end
            end
`endif
          end else begin
            state_q <= StIdle;
            right   <= 1'b0;
            error   <= 1'b0;
          end
        end
`ifdef CONFIRM_LOCKOUT_EN
        StLocked: begin
          right <= 1'b0;
          error <= 1'b1;
        end
`endif
        default: begin
          state_q <= StIdle;
          right   <= 1'b0;
          error   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_password_confirm.sv
// Directed bench for password_confirm: a vector table plus hand-written reset/lockout sequences.
module tb_password_confirm;

  logic        clk;
  logic        rst;
  logic        changePass;
  logic        confirmPass;
  logic [15:0] password;
  logic        error;
  logic        right;

  int errors = 0;
  int checks = 0;

  password_confirm dut (
    .clk         (clk),
    .rst         (rst),
    .changePass  (changePass),
    .confirmPass (confirmPass),
    .password    (password),
    .error       (error),
    .right       (right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic        cf;
    logic [15:0] pw;
    logic        exp_r;
    logic        exp_e;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic exp_r, input logic exp_e);
    checks++;
    if (right !== exp_r || error !== exp_e) begin
      errors++;
      $display("FAIL %s: got right=%0b error=%0b, expected right=%0b error=%0b",
               name, right, error, exp_r, exp_e);
    end
  endtask

  // Drive inputs just after a negedge; the next negedge follows one posedge.
  task automatic apply(input logic ch, input logic cf, input logic [15:0] pw);
    changePass  = ch;
    confirmPass = cf;
    password    = pw;
    @(negedge clk);
  endtask

  task automatic apply_check(input string name, input logic ch, input logic cf,
                             input logic [15:0] pw, input logic exp_r, input logic exp_e);
    apply(ch, cf, pw);
    check(name, exp_r, exp_e);
  endtask

  task automatic do_reset();
    changePass  = 1'b0;
    confirmPass = 1'b0;
    password    = 16'h0000;
    #2 rst = 1'b0;
    #1 check("async_reset", 1'b0, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h4781, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h4781, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 16'h4781, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 16'h4781, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 16'h4102, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 16'h4102, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 16'h4102, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h1874, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'h4102, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 16'h4A02, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 16'h4102, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 16'h4102, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst         = 1'b0;
    changePass  = 1'b0;
    confirmPass = 1'b0;
    password    = 16'h0000;
    #1 check("reset_state", 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("reset_held", 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply_check($sformatf("vec%0d", i), vecs[i].ch, vecs[i].cf, vecs[i].pw,
                  vecs[i].exp_r, vecs[i].exp_e);
    end

    // Last accepted value of a write burst is kept.
    apply_check("wr_a", 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    apply_check("wr_b", 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0);
    apply_check("wr_bad", 1'b1, 1'b0, 16'h999F, 1'b0, 1'b1);
    apply_check("wr_idle", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    apply_check("old_a", 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1);
    apply_check("new_b", 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0);
    apply_check("non_bcd_cmp", 1'b0, 1'b1, 16'h2A22, 1'b0, 1'b1);

    // Reset mid-confirm restores the default code.
    apply_check("pre_rst", 1'b0, 1'b1, 16'h2222, 1'b1, 1'b0);
    do_reset();
    apply_check("post_rst_old", 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1);
    apply_check("post_rst_def", 1'b0, 1'b1, 16'h4781, 1'b1, 1'b0);
    apply_check("post_rst_idle", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      apply_check($sformatf("bad_try%0d", i), 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
      apply(1'b0, 1'b0, 16'h0000);
    end
`ifdef CONFIRM_LOCKOUT_EN
    check("locked_idle", 1'b0, 1'b1);
    apply_check("locked_good", 1'b0, 1'b1, 16'h4781, 1'b0, 1'b1);
    apply_check("locked_write", 1'b1, 1'b0, 16'h4102, 1'b0, 1'b1);
    apply_check("locked_hold", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_reset();
    apply_check("unlock_good", 1'b0, 1'b1, 16'h4781, 1'b1, 1'b0);
`else
    check("no_lock_idle", 1'b0, 1'b0);
    apply_check("no_lock_good", 1'b0, 1'b1, 16'h4781, 1'b1, 1'b0);
    apply_check("no_lock_drop", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
